// File: rtl/layer_sched.sv
// Layer sequencer: time-multiplexes one neuron pipeline across N_NEURON neurons,
// tracks in-flight indices and streams results out under valid/ready backpressure.
module layer_sched #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned N_NEURON   = 3,
    parameter int unsigned NEURON_LAT = 4,
    parameter int unsigned ADDR_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  x_1,
    input  logic [WIDTH-1:0]  x_2,
    input  logic [WIDTH-1:0]  x_3,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [WIDTH-1:0]  w_1,
    input  logic [WIDTH-1:0]  w_2,
    input  logic [WIDTH-1:0]  w_3,
    input  logic [WIDTH-1:0]  b_in,
    output logic              n_en,
    output logic [WIDTH-1:0]  n_a1,
    output logic [WIDTH-1:0]  n_a2,
    output logic [WIDTH-1:0]  n_a3,
    output logic [WIDTH-1:0]  n_w1,
    output logic [WIDTH-1:0]  n_w2,
    output logic [WIDTH-1:0]  n_w3,
    output logic [WIDTH-1:0]  n_b,
    input  logic [WIDTH-1:0]  n_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [WIDTH-1:0]  out_data
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_NEURON - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a1, a2, a3;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   out_cnt;
    logic               pipe_vld [NEURON_LAT];
    logic [ADDR_W-1:0]  pipe_idx [NEURON_LAT];

    logic issuing;
    logic issue_fire;
    logic take;

    // Whole pipeline (neuron, tracker, issue counter) freezes while the head result is refused
    assign issuing    = (state == S_ISSUE);
    assign n_en       = busy & ~(out_valid & ~out_ready);
    assign issue_fire = issuing & n_en;
    assign take       = out_valid & out_ready;

    assign out_valid = pipe_vld[NEURON_LAT-1];
    assign out_idx   = pipe_idx[NEURON_LAT-1];
    assign out_data  = out_valid ? n_y : '0;

    assign w_addr = issuing ? issue_cnt[ADDR_W-1:0] : '0;
    assign n_a1   = a1;
    assign n_a2   = a2;
    assign n_a3   = a3;
    assign n_w1   = issuing ? w_1  : '0;
    assign n_w2   = issuing ? w_2  : '0;
    assign n_w3   = issuing ? w_3  : '0;
    assign n_b    = issuing ? b_in : '0;

    // Control FSM with registered busy/done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            a1        <= '0;
            a2        <= '0;
            a3        <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (take) begin
                out_cnt <= out_cnt + CNT_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a1        <= x_1;
                        a2        <= x_2;
                        a3        <= x_3;
                        issue_cnt <= '0;
                        out_cnt   <= '0;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (n_en) begin
                        issue_cnt <= issue_cnt + CNT_W'(1);
                        if (issue_cnt == LAST) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (take && out_cnt == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // In-flight tracker mirroring the neuron latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NEURON_LAT); i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_idx[i] <= '0;
            end
        end else if (n_en) begin
            pipe_vld[0] <= issue_fire;
            pipe_idx[0] <= issue_fire ? issue_cnt[ADDR_W-1:0] : '0;
            for (int i = 1; i < int'(NEURON_LAT); i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

endmodule

// File: doc/layer_sched.md
# layer_sched

Sequencing controller that time-multiplexes one `neuron_a` datapath (3-input MAC plus bias, tanh activation, Q8.24) across the `N_NEURON` neurons of a fully connected layer. On `start` it latches the three layer inputs, walks the weight memory one neuron per cycle, and drives the neuron pipeline back-to-back. It tracks each in-flight neuron through the pipeline latency and streams the results out with a valid/ready handshake, stalling the whole pipeline under backpressure. It sits between the layer-level top (input/output buffers) and one `neuron_a` instance plus its weight ROM/regfile.

## Interface
- `WIDTH`, 32, data width, Q8.24 signed
- `N_NEURON`, 3, neurons in the layer, ≥1
- `NEURON_LAT`, 4, enabled clock edges from operands on `n_*` to valid `n_y`, ≥1
- `ADDR_W`, 2, width of `w_addr` / `out_idx`; must satisfy 2^ADDR_W ≥ N_NEURON

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset; also wired to the neuron's `rst`
- `start`  in  1  begin a layer pass; sampled only in IDLE
- `x_1`,`x_2`,`x_3`  in  WIDTH  layer inputs, latched on accepted `start`
- `busy`  out  1  high from the cycle after start acceptance until `done`
- `done`  out  1  one-cycle pulse after the last result handshake
- `w_addr`  out  ADDR_W  weight memory address (neuron index being issued)
- `w_1`,`w_2`,`w_3`,`b_in`  in  WIDTH  weight/bias for `w_addr`, combinational read, same cycle
- `n_en`  out  1  neuron pipeline enable
- `n_a1`,`n_a2`,`n_a3`,`n_w1`,`n_w2`,`n_w3`,`n_b`  out  WIDTH  neuron operands
- `n_y`  in  WIDTH  neuron output
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts result
- `out_idx`  out  ADDR_W  neuron index of current result
- `out_data`  out  WIDTH  equals `n_y` while `out_valid`

## Operation
- FSM states:
  - IDLE: `start`=1 latches `x_*` into `a_*` regs, clears counters, goes to ISSUE.
  - ISSUE: issues neuron `issue_cnt` each enabled cycle; after index N_NEURON-1 is issued, goes to DRAIN.
  - DRAIN: waits until all in-flight results are accepted, then goes to DONE.
  - DONE: lasts one cycle with `done`=1, then IDLE.
- `w_addr` = `issue_cnt` in ISSUE, otherwise 0. `n_a*` = latched inputs. `n_w*`/`n_b` = `w_*`/`b_in` when issuing, otherwise 0.
- Tracking pipe: a `NEURON_LAT`-deep shift register of {valid, idx}. It shifts on `n_en`. The head is loaded with {1, issue_cnt} on an issue cycle, otherwise {0, x}. The tail drives `out_valid`/`out_idx`.
- Stall: `n_en` = busy AND NOT (`out_valid` AND NOT `out_ready`). When `n_en`=0, the neuron registers, tracking pipe and `issue_cnt` all hold, so results are never lost or duplicated.
- A result is consumed when `out_valid` AND `out_ready`. `out_cnt` counts consumed results; DRAIN exits when `out_cnt` = N_NEURON.
- `start` while busy is ignored. Results are emitted strictly in index order 0..N_NEURON-1.
- Arithmetic: the controller does none. Counters are ADDR_W+1 bits wide to reach N_NEURON without wrap.

## Timing
- Reset values (asynchronous): state=IDLE; `busy`, `done`, `n_en`, `out_valid` = 0; `w_addr`, `out_idx`, `out_data` path, counters, tracking pipe and `a_*` regs = 0.
- `start` high at cycle T in IDLE:
  - `busy`=1 and first issue (idx 0) at T+1.
  - With no stall, idx k issues at T+1+k.
  - idx k gives `out_valid` at T+1+k+NEURON_LAT.
- No stall: `done` at T+N_NEURON+NEURON_LAT+1, `busy` falls in that same cycle. Next `start` is accepted the cycle after.
- Each cycle of `out_ready`=0 while `out_valid`=1 delays every later event by exactly one cycle.
- `rst` mid-pass: all state clears immediately, and the neuron is cleared via the shared `rst`. No `done` is emitted. After release, IDLE waits for a fresh `start`.
- N_NEURON=1: single issue; `done` at T+NEURON_LAT+2.

## Test plan
- Basic pass, N=3, LAT=4, all ready:
  - Stimulus: x=1.0 (0x01000000), all weights 0, biases 0, `start` at T.
  - Response: `w_addr` 0,1,2 at T+1..T+3; `out_valid` idx 0,1,2 at T+5..T+7 with `out_data`=0; `done` at T+8.
- Per-neuron values:
  - Stimulus: neuron k weights=(k·0.25) each, bias 0.
  - Response: `out_data` matches the golden tanh(0.75k) model within 1 LSB of tanh table error; index order 0,1,2.
- Backpressure:
  - Stimulus: `out_ready`=0 for 3 cycles when idx 1 is first valid.
  - Response: idx 1 held stable for 4 cycles, `n_en`=0 during the stall, no result lost; `done` at T+11.
- `start` while busy: second `start` pulse at T+3 is ignored, exactly 3 results and one `done`.
- Reset mid-pass:
  - Stimulus: `rst` at T+4.
  - Response: all outputs 0 within the same cycle, no `done`; a new `start` afterwards completes a normal pass.
- Back-to-back: `start` at the cycle after `done` is accepted; the second pass's results use the newly latched x.
